pc_ctrl: RTL and testbench
==========================

Name: pc_ctrl

Overview:
- Next-PC sequencer that drives the program counter's jump controls: jmp_en, absjump_en and target.
- Turns decoded branch/call/return/halt requests into PC commands, holds the PC on stall, and issues a one-cycle pipeline flush after every taken redirect.
- Owns a small return-address stack (RAS) for call/return.
- Sits between decode/ALU flags and the PC register.

Parameters:
- D, 10, PC/target width (matches PC).
- RAS_DEPTH, 4, return-address stack entries (power of 2, >=2).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset; 0 resets all state immediately.
- start  in  1  leave IDLE/HALT and begin execution.
- stall  in  1  pipeline stall; PC must hold.
- halt_req  in  1  decoded halt instruction.
- br_valid  in  1  decoded control-transfer instruction present.
- br_type  in  2  0=REL (conditional relative), 1=ABS (unconditional absolute), 2=CALL, 3=RET.
- br_cond  in  1  condition flag for REL.
- br_target  in  D  REL: signed offset; ABS/CALL: absolute address; ignored for RET.
- prog_ctr  in  D  current PC value.
- jmp_en  out  1  to PC.
- absjump_en  out  1  to PC.
- target  out  D  to PC.
- flush  out  1  squash the fetched instruction; registered.
- done  out  1  program halted; registered.
- ras_err  out  1  sticky stack overflow/underflow; registered.

Behaviour:
- PC command encoding, combinational from state and inputs, no added latency:
  - HOLD: jmp_en=1, absjump_en=0, target=0 (PC+0).
  - INC: jmp_en=0, absjump_en=0, target=0.
  - REL: jmp_en=1, absjump_en=0, target=br_target.
  - ABS: jmp_en=1, absjump_en=1, target=address.
- Reset (reset=0): state=IDLE, RAS pointer sp=0, flush=0, done=0, ras_err=0. RAS contents don't-care.
- FSM states: IDLE, RUN, REDIRECT, HALT.
- IDLE: HOLD. start -> RUN next cycle.
- RUN, priority order:
  1. stall: HOLD, stay in RUN, no RAS change.
  2. halt_req: HOLD, -> HALT, done=1 next cycle. Any br_valid in the same cycle is ignored.
  3. br_valid:
     - REL with br_cond=1: REL command, -> REDIRECT.
     - REL with br_cond=0: INC, stay in RUN.
     - ABS: ABS to br_target, -> REDIRECT.
     - CALL: push (prog_ctr+1) mod 2^D, ABS to br_target, -> REDIRECT.
     - RET: pop, ABS to the popped address, -> REDIRECT.
  4. Otherwise: INC.
- REDIRECT: flush=1 during this state (registered on the transition). br_valid and halt_req are ignored.
  - stall: HOLD, remain in REDIRECT, flush stays 1.
  - No stall: INC, -> RUN.
- HALT: HOLD, done=1. start -> RUN; done clears on the following edge. ras_err is unaffected by start.
- RAS rules:
  - CALL with sp==RAS_DEPTH (full): no push, no jump (HOLD), ras_err=1, -> HALT.
  - RET with sp==0 (empty): HOLD, ras_err=1, -> HALT.
  - sp changes only on a successful push or pop.
- Arithmetic: REL offset addition is done in the PC and wraps mod 2^D. The return address wraps mod 2^D (prog_ctr=2^D-1 pushes 0).
- Reset asserted mid-operation: immediate return to IDLE with all registered outputs at 0, including an in-flight REDIRECT.

Decomposition:
- Package pc_ctrl_pkg: br_type_e enum (BR_REL, BR_ABS, BR_CALL, BR_RET), state_e enum, PC command constants.
- Sub-module pc_ras: RAS_DEPTH x D stack.
  - Ports: clk, reset, push, pop, wdata, rdata, full, empty.
  - Same-cycle push+pop is illegal; the controller never issues it.

Test Plan:
- Reset, start, 3 idle cycles: jmp_en=0 each RUN cycle; PC goes 0->1->2->3. flush=0, done=0.
- REL taken, prog_ctr=5, br_target=-2 (D'h3FE), br_cond=1: jmp_en=1, absjump_en=0, target=3FE; PC=3; flush=1 for exactly one cycle. Same stimulus with br_cond=0: PC=6, no flush.
- CALL at prog_ctr=20 to 100, then RET at 105: PC=100 then PC=21; sp goes 0->1->0; flush after each.
- RAS_DEPTH+1 nested CALLs: the fifth CALL gives HOLD, ras_err=1, done=1, and PC does not change. A RET on an empty stack after reset and start gives the same error.
- Stall for 3 cycles during RUN and during REDIRECT: PC constant (HOLD), state retained, flush held high throughout the REDIRECT stall.
- halt_req with br_valid (ABS) in the same cycle: HOLD, done=1, no jump. start then resumes INC. An async reset asserted mid-REDIRECT clears flush, done, ras_err and sp without waiting for a clock edge.

Source files
------------

// File: rtl/pc_ctrl_pkg.sv
// pc_ctrl_pkg: shared types and PC command encodings for the next-PC sequencer
package pc_ctrl_pkg;
  typedef enum logic [1:0] {BR_REL, BR_ABS, BR_CALL, BR_RET} br_type_e;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_REDIRECT, S_HALT} state_e;
  typedef enum logic [3:0] {A_HOLD, A_START, A_INC, A_REL, A_JMP, A_CALL, A_RET, A_HALT, A_ERR} act_e;
  typedef struct packed {logic jmp; logic abs;} pc_cmd_t;
  localparam pc_cmd_t CMD_HOLD = '{jmp: 1'b1, abs: 1'b0};
  localparam pc_cmd_t CMD_INC  = '{jmp: 1'b0, abs: 1'b0};
  localparam pc_cmd_t CMD_REL  = '{jmp: 1'b1, abs: 1'b0};
  localparam pc_cmd_t CMD_ABS  = '{jmp: 1'b1, abs: 1'b1};
  function automatic pc_cmd_t act_cmd(input act_e a);
    return (a == A_INC) ? CMD_INC :
           (a == A_REL) ? CMD_REL :
           (a inside {A_JMP, A_CALL, A_RET}) ? CMD_ABS : CMD_HOLD;
  endfunction
endpackage

// File: rtl/pc_ras.sv
// pc_ras: return-address stack, sp counts valid entries, top entry at sp-1
module pc_ras #(
  parameter int D = 10,
  parameter int RAS_DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [D-1:0] wdata,
  output logic [D-1:0] rdata,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(RAS_DEPTH);
  logic [D-1:0] mem [RAS_DEPTH];
  logic [AW:0] sp;
  logic [AW-1:0] top;
  assign top = sp[AW-1:0] - AW'(1);
  assign full = sp == (AW+1)'(RAS_DEPTH);
  assign empty = sp == '0;
  assign rdata = mem[top];
  // storage needs no reset; entries above sp are never read
  always_ff @(posedge clk)
    if (push && !full) mem[sp[AW-1:0]] <= wdata;
  // stack pointer moves only on a push or pop that can succeed
  always_ff @(posedge clk or negedge reset)
    if (!reset) sp <= '0;
    else if (push && !full) sp <= sp + (AW+1)'(1);
    else if (pop && !empty) sp <= sp - (AW+1)'(1);
endmodule

// File: rtl/pc_ctrl.sv
// pc_ctrl: next-PC sequencer driving jump controls, flush, halt and a return-address stack
module pc_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter int D = 10,
  parameter int RAS_DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         stall,
  input  logic         halt_req,
  input  logic         br_valid,
  input  logic [1:0]   br_type,
  input  logic         br_cond,
  input  logic [D-1:0] br_target,
  input  logic [D-1:0] prog_ctr,
  output logic         jmp_en,
  output logic         absjump_en,
  output logic [D-1:0] target,
  output logic         flush,
  output logic         done,
  output logic         ras_err
);
  state_e state, nxt;
  act_e act;
  pc_cmd_t cmd;
  br_type_e bt;
  logic push, pop, full, empty;
  logic [D-1:0] rdata;
  assign bt = br_type_e'(br_type);
  // decide this cycle's action; stall beats halt, halt beats any branch
  always_comb begin
    act = A_HOLD;
    unique case (state)
      S_IDLE, S_HALT: act = start ? A_START : A_HOLD;
      S_REDIRECT:     act = stall ? A_HOLD : A_INC;
      S_RUN:
        if (stall) act = A_HOLD;
        else if (halt_req) act = A_HALT;
        else if (!br_valid) act = A_INC;
        else
          unique case (bt)
            BR_REL:  act = br_cond ? A_REL : A_INC;
            BR_ABS:  act = A_JMP;
            BR_CALL: act = full ? A_ERR : A_CALL;
            BR_RET:  act = empty ? A_ERR : A_RET;
            default: act = A_HOLD;
          endcase
      default: act = A_HOLD;
    endcase
  end
  // next state follows directly from the chosen action
  always_comb begin
    nxt = state;
    unique case (act)
      A_START, A_INC:               nxt = S_RUN;
      A_REL, A_JMP, A_CALL, A_RET:  nxt = S_REDIRECT;
      A_HALT, A_ERR:                nxt = S_HALT;
      default:                      nxt = state;
    endcase
  end
  // PC command and target; RET jumps to the stacked return address
  always_comb begin
    cmd = act_cmd(act);
    target = (act == A_RET) ? rdata : (act inside {A_REL, A_JMP, A_CALL}) ? br_target : '0;
  end
  assign jmp_en = cmd.jmp;
  assign absjump_en = cmd.abs;
  assign push = act == A_CALL;
  assign pop = act == A_RET;
  // state register
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= S_IDLE;
    else state <= nxt;
  // registered status flags; ras_err is sticky until reset
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      flush <= 1'b0;
      done <= 1'b0;
      ras_err <= 1'b0;
    end else begin
      flush <= nxt == S_REDIRECT;
      done <= nxt == S_HALT;
      ras_err <= ras_err | (act == A_ERR);
    end
  pc_ras #(.D(D), .RAS_DEPTH(RAS_DEPTH)) u_ras (
    .clk(clk),
    .reset(reset),
    .push(push),
    .pop(pop),
    .wdata(prog_ctr + D'(1)),
    .rdata(rdata),
    .full(full),
    .empty(empty)
  );
endmodule

// File: tb/tb_pc_ctrl.sv
// tb_pc_ctrl: directed checks of pc_ctrl with a bench-side PC register
module tb_pc_ctrl;
  import pc_ctrl_pkg::*;
  logic clk = 1'b0, reset = 1'b0, start = 1'b0, stall = 1'b0, halt_req = 1'b0;
  logic br_valid = 1'b0, br_cond = 1'b0;
  logic [1:0] br_type = 2'd0;
  logic [9:0] br_target = '0, prog_ctr, target;
  logic jmp_en, absjump_en, flush, done, ras_err;
  logic [9:0] pc = '0;
  int checks = 0, passed = 0, fails = 0;
  assign prog_ctr = pc;
  always #5 clk = ~clk;
  pc_ctrl #(.D(10), .RAS_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .start(start), .stall(stall), .halt_req(halt_req),
    .br_valid(br_valid), .br_type(br_type), .br_cond(br_cond), .br_target(br_target),
    .prog_ctr(prog_ctr), .jmp_en(jmp_en), .absjump_en(absjump_en), .target(target),
    .flush(flush), .done(done), .ras_err(ras_err)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    logic [9:0] n;
    #1;
    n = jmp_en ? (absjump_en ? target : pc + target) : pc + 10'd1;
    @(posedge clk);
    #1;
    pc = n;
  endtask
  task automatic br(input logic [1:0] t, input logic [9:0] tg, input logic c);
    br_valid = 1'b1;
    br_type = t;
    br_target = tg;
    br_cond = c;
  endtask
  task automatic nobr();
    br_valid = 1'b0;
  endtask
  initial begin
    #3;
    chk("rst_flush", 32'(flush), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(ras_err), 0);
    chk("rst_sp", 32'(dut.u_ras.sp), 0);
    @(posedge clk); #1 reset = 1'b1; #1;
    chk("idle_jmp", 32'(jmp_en), 1);
    chk("idle_tgt", 32'(target), 0);
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1 chk("run_inc_jmp", 32'(jmp_en), 0);
      step();
    end
    chk("run_pc", 32'(pc), 3);
    chk("run_flush", 32'(flush), 0);
    chk("run_done", 32'(done), 0);
    pc = 10'd5; br(BR_REL, 10'h3FE, 1'b1); #1;
    chk("rel_jmp", 32'(jmp_en), 1);
    chk("rel_abs", 32'(absjump_en), 0);
    chk("rel_tgt", 32'(target), 'h3FE);
    step(); nobr();
    chk("rel_pc", 32'(pc), 3);
    chk("rel_flush", 32'(flush), 1);
    #1 chk("redir_inc", 32'(jmp_en), 0);
    step();
    chk("rel_flush_once", 32'(flush), 0);
    pc = 10'd5; br(BR_REL, 10'h3FE, 1'b0); #1;
    chk("reln_jmp", 32'(jmp_en), 0);
    step(); nobr();
    chk("reln_pc", 32'(pc), 6);
    chk("reln_flush", 32'(flush), 0);
    pc = 10'd20; br(BR_CALL, 10'd100, 1'b0); #1;
    chk("call_abs", 32'(absjump_en), 1);
    chk("call_tgt", 32'(target), 100);
    step(); nobr();
    chk("call_pc", 32'(pc), 100);
    chk("call_flush", 32'(flush), 1);
    chk("call_sp", 32'(dut.u_ras.sp), 1);
    step();
    pc = 10'd105; br(BR_RET, 10'd0, 1'b0); #1;
    chk("ret_tgt", 32'(target), 21);
    step(); nobr();
    chk("ret_pc", 32'(pc), 21);
    chk("ret_flush", 32'(flush), 1);
    chk("ret_sp", 32'(dut.u_ras.sp), 0);
    step();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 chk("stall_jmp", 32'(jmp_en), 1);
      chk("stall_tgt", 32'(target), 0);
      step();
    end
    stall = 1'b0;
    chk("stall_pc", 32'(pc), 22);
    br(BR_ABS, 10'd50, 1'b0); step(); nobr(); stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 chk("rstall_flush", 32'(flush), 1);
      chk("rstall_jmp", 32'(jmp_en), 1);
      step();
    end
    stall = 1'b0;
    chk("rstall_pc", 32'(pc), 50);
    #1 chk("rstall_inc", 32'(jmp_en), 0);
    step();
    chk("rstall_flush_end", 32'(flush), 0);
    chk("rstall_pc2", 32'(pc), 51);
    halt_req = 1'b1; br(BR_ABS, 10'd200, 1'b0); #1;
    chk("halt_jmp", 32'(jmp_en), 1);
    chk("halt_abs", 32'(absjump_en), 0);
    chk("halt_tgt", 32'(target), 0);
    step(); halt_req = 1'b0; nobr();
    chk("halt_pc", 32'(pc), 51);
    chk("halt_done", 32'(done), 1);
    chk("halt_flush", 32'(flush), 0);
    start = 1'b1; step(); start = 1'b0;
    chk("resume_done", 32'(done), 0);
    #1 chk("resume_inc", 32'(jmp_en), 0);
    step();
    chk("resume_pc", 32'(pc), 52);
    for (int i = 0; i < 4; i++) begin
      pc = 10'(10 * (i + 1)); br(BR_CALL, 10'(300 + i), 1'b0); step(); nobr(); step();
    end
    chk("full_sp", 32'(dut.u_ras.sp), 4);
    pc = 10'd77; br(BR_CALL, 10'd400, 1'b0); #1;
    chk("ovf_jmp", 32'(jmp_en), 1);
    chk("ovf_abs", 32'(absjump_en), 0);
    chk("ovf_tgt", 32'(target), 0);
    step(); nobr();
    chk("ovf_pc", 32'(pc), 77);
    chk("ovf_err", 32'(ras_err), 1);
    chk("ovf_done", 32'(done), 1);
    chk("ovf_sp", 32'(dut.u_ras.sp), 4);
    reset = 1'b0; #1;
    chk("arst_err", 32'(ras_err), 0);
    chk("arst_done", 32'(done), 0);
    chk("arst_sp", 32'(dut.u_ras.sp), 0);
    #1 reset = 1'b1;
    start = 1'b1; step(); start = 1'b0;
    br(BR_RET, 10'd0, 1'b0); #1;
    chk("unf_jmp", 32'(jmp_en), 1);
    chk("unf_abs", 32'(absjump_en), 0);
    step(); nobr();
    chk("unf_err", 32'(ras_err), 1);
    chk("unf_done", 32'(done), 1);
    chk("unf_pc", 32'(pc), 77);
    start = 1'b1; step(); start = 1'b0;
    chk("sticky_err", 32'(ras_err), 1);
    chk("sticky_done", 32'(done), 0);
    pc = 10'h3FF; br(BR_CALL, 10'd5, 1'b0); step(); nobr(); step();
    br(BR_RET, 10'd0, 1'b0); #1;
    chk("wrap_tgt", 32'(target), 0);
    step(); nobr(); step();
    pc = 10'd9; br(BR_CALL, 10'd7, 1'b0); step(); nobr();
    chk("mid_flush", 32'(flush), 1);
    chk("mid_sp", 32'(dut.u_ras.sp), 1);
    reset = 1'b0; #1;
    chk("mid_rst_flush", 32'(flush), 0);
    chk("mid_rst_err", 32'(ras_err), 0);
    chk("mid_rst_sp", 32'(dut.u_ras.sp), 0);
    chk("mid_rst_done", 32'(done), 0);
    chk("mid_rst_hold", 32'(jmp_en), 1);
    #1 reset = 1'b1;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
